execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage of the 5-stage scalar/vector pipeline.
- Holds the Decode→Execute pipeline register: latches the 20-bit control word, the operands and the register indices.
- Contains the 8-bit scalar ALU and the 128-bit (16×8-bit lane) vector ALU, both combinational.
- ALU operands come from the external forwarding muxes, which are fed by this block's registered operands.

Parameters:
- none (widths fixed: scalar 16-bit datapath/8-bit ALU, vector 128-bit, 5-bit register indices, 20-bit control word)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears the pipeline register
- nop_mux_output_in  in  20  control word from the decode NOP mux (0 = bubble)
- srcA_in, srcB_in  in  16  scalar regfile read data
- srcA_vector_in, srcB_vector_in  in  128  vector regfile read data
- rs1_decode, rs2_decode, rd_decode  in  5  register indices
- alu_src_A, alu_src_B  in  16  forwarded scalar operands (only [7:0] used)
- alu_src_vector_A, alu_src_vector_B  in  128  forwarded vector operands
- wre_execute, vector_wre_execute  out  1  scalar/vector regfile write enables
- write_memory_enable_a_execute, write_memory_enable_b_execute  out  1  RAM port A/B write enables
- select_writeback_data_mux_execute, select_writeback_vector_data_mux_execute  out  2  writeback mux selects
- aluOp_execute, aluVectorOp_execute  out  5  ALU opcodes
- load_instruction  out  1  marks a load in Execute (hazard unit)
- srcA_out, srcB_out  out  16  registered scalar operands
- srcA_vector_out, srcB_vector_out  out  128  registered vector operands
- rs1_execute, rs2_execute, rd_execute  out  5  registered indices
- alu_result_execute  out  8  scalar ALU result
- alu_vector_result_execute  out  128  vector ALU result

Behaviour:
- Pipeline register updates on every rising clk edge; no stall or enable input (stall is a zero control word).
- reset=1 forces all registered outputs to 0 immediately, independent of clk. This holds mid-operation; the first capture after reset release happens on the next rising edge.
- Control word decode, latched from nop_mux_output_in:
  - [19] wre
  - [18] vector_wre
  - [17] wmem_a
  - [16] wmem_b
  - [15:14] sel_wb
  - [13:12] sel_vwb
  - [11:7] aluOp
  - [6:2] aluVectorOp
  - [1] load_instruction
  - [0] reserved, ignored
- Control word all-zero gives a bubble: no writes, aluOp 0.
- One-cycle latency: values present before edge N appear on the outputs after edge N.
- Scalar ALU is combinational on A=alu_src_A[7:0], B=alu_src_B[7:0]; results are mod 256. Opcodes:
  - 0 ADD
  - 1 SUB (A−B, wraps)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL by B[2:0]
  - 6 SRL by B[2:0]
  - 7 ROL by B[2:0]
  - 8 ROR by B[2:0]
  - 9 MUL low 8 bits
  - 10 pass A
  - 11 pass B
  - other codes → 0
- Vector ALU is combinational and lane-wise: lane i = bits [8i+7:8i], i = 0..15, with no carries between lanes.
  - Opcodes 0–8 as scalar, using per-lane B.
  - 9: scalar-broadcast ADD (every lane + B lane 0).
  - 10 pass A.
  - Other codes → 0.
- ALU outputs depend only on the current operand inputs and opcode outputs; they are not registered.

Test Plan:
- Reset: assert reset mid-cycle with non-zero registered state → all register outputs 0 without a clock edge; ALU result for aluOp 0 with zero operands = 0x00.
- Capture: nop_mux_output_in=0x80000 (wre only), srcA_in=0x0012, rd_decode=5, then one edge → wre_execute=1, all other controls 0, srcA_out=0x0012, rd_execute=5.
- Bubble: zero control word after a valid one → all control outputs 0 on the next edge; operands and indices still captured.
- Scalar ALU: A=0xF0, B=0x20: ADD→0x10, SUB→0xD0, XOR→0xD0; A=0x81, B=3: ROL→0x0C.
- Vector ALU: A lanes all 0xFF, B lanes all 0x01, op ADD → all lanes 0x00 with no inter-lane carry (result 128'h0); op 9 with B lane0=2 → all lanes 0x01.
- Full decode: control word with every defined field set to distinct values (aluOp=0x1F, aluVectorOp=0x15, sel_wb=2, sel_vwb=1, load=1) → each output reflects its own field exactly.

Source files
------------

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Execute stage: Decode->Execute pipeline register plus scalar and vector ALUs
module execute_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic [19:0]  nop_mux_output_in,
    input  logic [15:0]  srcA_in,
    input  logic [15:0]  srcB_in,
    input  logic [127:0] srcA_vector_in,
    input  logic [127:0] srcB_vector_in,
    input  logic [4:0]   rs1_decode,
    input  logic [4:0]   rs2_decode,
    input  logic [4:0]   rd_decode,
    input  logic [15:0]  alu_src_A,
    input  logic [15:0]  alu_src_B,
    input  logic [127:0] alu_src_vector_A,
    input  logic [127:0] alu_src_vector_B,
    output logic         wre_execute,
    output logic         vector_wre_execute,
    output logic         write_memory_enable_a_execute,
    output logic         write_memory_enable_b_execute,
    output logic [1:0]   select_writeback_data_mux_execute,
    output logic [1:0]   select_writeback_vector_data_mux_execute,
    output logic [4:0]   aluOp_execute,
    output logic [4:0]   aluVectorOp_execute,
    output logic         load_instruction,
    output logic [15:0]  srcA_out,
    output logic [15:0]  srcB_out,
    output logic [127:0] srcA_vector_out,
    output logic [127:0] srcB_vector_out,
    output logic [4:0]   rs1_execute,
    output logic [4:0]   rs2_execute,
    output logic [4:0]   rd_execute,
    output logic [7:0]   alu_result_execute,
    output logic [127:0] alu_vector_result_execute
);

    // Scalar ALU only looks at the low byte; control bit 0 is reserved.
    logic unused_bits;
    assign unused_bits = &{1'b0, alu_src_A[15:8], alu_src_B[15:8], nop_mux_output_in[0]};

    // One 8-bit lane: shared by the scalar ALU and each vector lane.
    function automatic logic [7:0] lane_alu(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [2:0] sh;
        logic [3:0] inv;
        sh  = b[2:0];
        inv = 4'd8 - {1'b0, sh};
        case (op)
            5'd0:    lane_alu = a + b;
            5'd1:    lane_alu = a - b;
            5'd2:    lane_alu = a & b;
            5'd3:    lane_alu = a | b;
            5'd4:    lane_alu = a ^ b;
            5'd5:    lane_alu = a << sh;
            5'd6:    lane_alu = a >> sh;
            5'd7:    lane_alu = (a << sh) | (a >> inv);
            5'd8:    lane_alu = (a >> sh) | (a << inv);
            5'd9:    lane_alu = a * b;
            5'd10:   lane_alu = a;
            5'd11:   lane_alu = b;
            default: lane_alu = 8'd0;
        endcase
    endfunction

    // Decode->Execute pipeline register; a zero control word is a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wre_execute                              <= 1'b0;
            vector_wre_execute                       <= 1'b0;
            write_memory_enable_a_execute            <= 1'b0;
            write_memory_enable_b_execute            <= 1'b0;
            select_writeback_data_mux_execute        <= 2'd0;
            select_writeback_vector_data_mux_execute <= 2'd0;
            aluOp_execute                            <= 5'd0;
            aluVectorOp_execute                      <= 5'd0;
            load_instruction                         <= 1'b0;
            srcA_out                                 <= 16'd0;
            srcB_out                                 <= 16'd0;
            srcA_vector_out                          <= 128'd0;
            srcB_vector_out                          <= 128'd0;
            rs1_execute                              <= 5'd0;
            rs2_execute                              <= 5'd0;
            rd_execute                               <= 5'd0;
        end else begin
            wre_execute                              <= nop_mux_output_in[19];
            vector_wre_execute                       <= nop_mux_output_in[18];
            write_memory_enable_a_execute            <= nop_mux_output_in[17];
            write_memory_enable_b_execute            <= nop_mux_output_in[16];
            select_writeback_data_mux_execute        <= nop_mux_output_in[15:14];
            select_writeback_vector_data_mux_execute <= nop_mux_output_in[13:12];
            aluOp_execute                            <= nop_mux_output_in[11:7];
            aluVectorOp_execute                      <= nop_mux_output_in[6:2];
            load_instruction                         <= nop_mux_output_in[1];
            srcA_out                                 <= srcA_in;
            srcB_out                                 <= srcB_in;
            srcA_vector_out                          <= srcA_vector_in;
            srcB_vector_out                          <= srcB_vector_in;
            rs1_execute                              <= rs1_decode;
            rs2_execute                              <= rs2_decode;
            rd_execute                               <= rd_decode;
        end
    end

    // Scalar ALU on the forwarded low bytes.
    always_comb begin
        alu_result_execute = lane_alu(aluOp_execute, alu_src_A[7:0], alu_src_B[7:0]);
    end

    // Vector ALU: 16 independent lanes; op 9 broadcasts B lane 0 into an add, op 11 is undefined here.
    always_comb begin
        alu_vector_result_execute = '0;
        for (int i = 0; i < 16; i++) begin
            if (aluVectorOp_execute == 5'd9)
                alu_vector_result_execute[8*i +: 8] = lane_alu(5'd0, alu_src_vector_A[8*i +: 8], alu_src_vector_B[7:0]);
            else if (aluVectorOp_execute == 5'd11)
                alu_vector_result_execute[8*i +: 8] = 8'd0;
            else
                alu_vector_result_execute[8*i +: 8] = lane_alu(aluVectorOp_execute, alu_src_vector_A[8*i +: 8],
                                                               alu_src_vector_B[8*i +: 8]);
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - Randomized self-checking bench for execute_stage
module tb_execute_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic [19:0]  nop_mux_output_in;
    logic [15:0]  srcA_in, srcB_in;
    logic [127:0] srcA_vector_in, srcB_vector_in;
    logic [4:0]   rs1_decode, rs2_decode, rd_decode;
    logic [15:0]  alu_src_A, alu_src_B;
    logic [127:0] alu_src_vector_A, alu_src_vector_B;
    logic         wre_execute, vector_wre_execute;
    logic         write_memory_enable_a_execute, write_memory_enable_b_execute;
    logic [1:0]   select_writeback_data_mux_execute, select_writeback_vector_data_mux_execute;
    logic [4:0]   aluOp_execute, aluVectorOp_execute;
    logic         load_instruction;
    logic [15:0]  srcA_out, srcB_out;
    logic [127:0] srcA_vector_out, srcB_vector_out;
    logic [4:0]   rs1_execute, rs2_execute, rd_execute;
    logic [7:0]   alu_result_execute;
    logic [127:0] alu_vector_result_execute;

    int n_cmp = 0;
    int n_bad = 0;

    execute_stage dut (
        .clk(clk), .reset(reset),
        .nop_mux_output_in(nop_mux_output_in),
        .srcA_in(srcA_in), .srcB_in(srcB_in),
        .srcA_vector_in(srcA_vector_in), .srcB_vector_in(srcB_vector_in),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
        .alu_src_A(alu_src_A), .alu_src_B(alu_src_B),
        .alu_src_vector_A(alu_src_vector_A), .alu_src_vector_B(alu_src_vector_B),
        .wre_execute(wre_execute), .vector_wre_execute(vector_wre_execute),
        .write_memory_enable_a_execute(write_memory_enable_a_execute),
        .write_memory_enable_b_execute(write_memory_enable_b_execute),
        .select_writeback_data_mux_execute(select_writeback_data_mux_execute),
        .select_writeback_vector_data_mux_execute(select_writeback_vector_data_mux_execute),
        .aluOp_execute(aluOp_execute), .aluVectorOp_execute(aluVectorOp_execute),
        .load_instruction(load_instruction),
        .srcA_out(srcA_out), .srcB_out(srcB_out),
        .srcA_vector_out(srcA_vector_out), .srcB_vector_out(srcB_vector_out),
        .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
        .alu_result_execute(alu_result_execute),
        .alu_vector_result_execute(alu_vector_result_execute)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int field(input int w, input int lo, input int n);
        return (w / (1 << lo)) % (1 << n);
    endfunction

    // Reference lane arithmetic straight from the opcode table, done on plain ints.
    function automatic int ref_lane(input int op, input int a, input int b);
        int s;
        s = b % 8;
        case (op)
            0:  return (a + b) % 256;
            1:  return (a - b + 256) % 256;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return (a * (1 << s)) % 256;
            6:  return a / (1 << s);
            7:  return ((a * (1 << s)) % 256) | (a / (1 << (8 - s)));
            8:  return (a / (1 << s)) | ((a * (1 << (8 - s))) % 256);
            9:  return (a * b) % 256;
            10: return a;
            11: return b;
            default: return 0;
        endcase
    endfunction

    function automatic logic [127:0] ref_vector(input int op, input logic [127:0] va, input logic [127:0] vb);
        logic [127:0] r;
        int a, b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            a = int'(va[8*i +: 8]);
            b = int'(vb[8*i +: 8]);
            if (op == 9)       r[8*i +: 8] = 8'((a + int'(vb[7:0])) % 256);
            else if (op <= 10) r[8*i +: 8] = 8'(ref_lane(op, a, b));
            else               r[8*i +: 8] = 8'd0;
        end
        return r;
    endfunction

    // Expected pipeline contents: whatever was presented before the last edge.
    logic [19:0]  e_cw;
    logic [15:0]  e_a, e_b;
    logic [127:0] e_va, e_vb;
    logic [4:0]   e_r1, e_r2, e_rd;

    task automatic drive(input logic [19:0] cw, input logic [15:0] a, input logic [15:0] b,
                         input logic [127:0] va, input logic [127:0] vb,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        nop_mux_output_in = cw; srcA_in = a; srcB_in = b;
        srcA_vector_in = va; srcB_vector_in = vb;
        rs1_decode = r1; rs2_decode = r2; rd_decode = rd;
        e_cw = cw; e_a = a; e_b = b; e_va = va; e_vb = vb; e_r1 = r1; e_r2 = r2; e_rd = rd;
    endtask

    task automatic check_pipe(input string tag, input logic [19:0] cw, input logic [15:0] a, input logic [15:0] b,
                              input logic [127:0] va, input logic [127:0] vb,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        int w;
        w = int'(cw);
        check({tag, ".wre"},   128'(wre_execute),                              128'(field(w, 19, 1)));
        check({tag, ".vwre"},  128'(vector_wre_execute),                       128'(field(w, 18, 1)));
        check({tag, ".wmema"}, 128'(write_memory_enable_a_execute),            128'(field(w, 17, 1)));
        check({tag, ".wmemb"}, 128'(write_memory_enable_b_execute),            128'(field(w, 16, 1)));
        check({tag, ".selwb"}, 128'(select_writeback_data_mux_execute),        128'(field(w, 14, 2)));
        check({tag, ".selvwb"},128'(select_writeback_vector_data_mux_execute), 128'(field(w, 12, 2)));
        check({tag, ".aluop"}, 128'(aluOp_execute),                            128'(field(w, 7, 5)));
        check({tag, ".valuop"},128'(aluVectorOp_execute),                      128'(field(w, 2, 5)));
        check({tag, ".load"},  128'(load_instruction),                         128'(field(w, 1, 1)));
        check({tag, ".srcA"},  128'(srcA_out), 128'(a));
        check({tag, ".srcB"},  128'(srcB_out), 128'(b));
        check({tag, ".vsrcA"}, srcA_vector_out, va);
        check({tag, ".vsrcB"}, srcB_vector_out, vb);
        check({tag, ".rs1"},   128'(rs1_execute), 128'(r1));
        check({tag, ".rs2"},   128'(rs2_execute), 128'(r2));
        check({tag, ".rd"},    128'(rd_execute),  128'(rd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] vtmp;
    logic [19:0]  cw;
    int           sops[3];
    logic [7:0]   sexp[3];

    initial begin
        reset = 1'b1;
        alu_src_A = '0; alu_src_B = '0; alu_src_vector_A = '0; alu_src_vector_B = '0;
        drive(20'hFFFFF, 16'hBEEF, 16'h1234, rand128(), rand128(), 5'd1, 5'd2, 5'd3);
        repeat (2) tick();
        check_pipe("rst", 20'd0, 16'd0, 16'd0, 128'd0, 128'd0, 5'd0, 5'd0, 5'd0);
        check("rst.alu", 128'(alu_result_execute), 128'd0);
        check("rst.valu", alu_vector_result_execute, 128'd0);

        // Capture of a wre-only control word
        @(negedge clk);
        reset = 1'b0;
        drive(20'h80000, 16'h0012, 16'h0000, 128'd0, 128'd0, 5'd0, 5'd0, 5'd5);
        tick();
        check("cap.wre", 128'(wre_execute), 128'd1);
        check("cap.srcA", 128'(srcA_out), 128'h0012);
        check("cap.rd", 128'(rd_execute), 128'd5);
        check_pipe("cap", e_cw, e_a, e_b, e_va, e_vb, e_r1, e_r2, e_rd);

        // Bubble still moves operands and indices
        @(negedge clk);
        drive(20'd0, 16'hA5A5, 16'h5A5A, rand128(), rand128(), 5'd7, 5'd9, 5'd31);
        tick();
        check_pipe("bubble", 20'd0, 16'hA5A5, 16'h5A5A, e_va, e_vb, 5'd7, 5'd9, 5'd31);

        // Scalar directed values
        sops = '{0, 1, 4};
        sexp = '{8'h10, 8'hD0, 8'hD0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cw = 20'(sops[k] * 128);
            drive(cw, 16'd0, 16'd0, 128'd0, 128'd0, 5'd0, 5'd0, 5'd0);
            tick();
            alu_src_A = 16'h33F0; alu_src_B = 16'hCC20;
            #1 check($sformatf("scalar.op%0d", sops[k]), 128'(alu_result_execute), 128'(sexp[k]));
        end
        @(negedge clk);
        drive(20'(7 * 128), 16'd0, 16'd0, 128'd0, 128'd0, 5'd0, 5'd0, 5'd0);
        tick();
        alu_src_A = 16'h0081; alu_src_B = 16'h0003;
        #1 check("scalar.rol", 128'(alu_result_execute), 128'h0C);

        // Vector directed: lane isolation and broadcast add
        @(negedge clk);
        drive(20'd0, 16'd0, 16'd0, 128'd0, 128'd0, 5'd0, 5'd0, 5'd0);
        tick();
        alu_src_vector_A = {16{8'hFF}}; alu_src_vector_B = {16{8'h01}};
        #1 check("vec.add_nocarry", alu_vector_result_execute, 128'd0);
        @(negedge clk);
        drive(20'(9 * 4), 16'd0, 16'd0, 128'd0, 128'd0, 5'd0, 5'd0, 5'd0);
        tick();
        vtmp = rand128();
        vtmp[7:0] = 8'h02;
        alu_src_vector_A = {16{8'hFF}}; alu_src_vector_B = vtmp;
        #1 check("vec.bcast", alu_vector_result_execute, {16{8'h01}});

        // Full decode with distinct field values
        @(negedge clk);
        cw = {1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1, 5'h1F, 5'h15, 1'b1, 1'b0};
        drive(cw, 16'hCAFE, 16'hF00D, rand128(), rand128(), 5'd17, 5'd22, 5'd30);
        tick();
        check("full.selwb", 128'(select_writeback_data_mux_execute), 128'd2);
        check("full.selvwb", 128'(select_writeback_vector_data_mux_execute), 128'd1);
        check("full.aluop", 128'(aluOp_execute), 128'h1F);
        check("full.valuop", 128'(aluVectorOp_execute), 128'h15);
        check("full.load", 128'(load_instruction), 128'd1);
        check_pipe("full", e_cw, e_a, e_b, e_va, e_vb, e_r1, e_r2, e_rd);

        // Asynchronous reset mid-cycle, away from any clock edge
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_pipe("arst", 20'd0, 16'd0, 16'd0, 128'd0, 128'd0, 5'd0, 5'd0, 5'd0);
        #1 reset = 1'b0;

        // Randomized traffic against the reference model
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            cw = 20'($urandom);
            cw[11:7] = 5'($urandom_range(0, 13));
            cw[6:2]  = 5'($urandom_range(0, 12));
            if (($urandom % 8) == 0) cw = 20'd0;
            drive(cw, 16'($urandom), 16'($urandom), rand128(), rand128(),
                  5'($urandom), 5'($urandom), 5'($urandom));
            tick();
            check_pipe("rnd", e_cw, e_a, e_b, e_va, e_vb, e_r1, e_r2, e_rd);
            alu_src_A = 16'($urandom); alu_src_B = 16'($urandom);
            alu_src_vector_A = rand128(); alu_src_vector_B = rand128();
            #1;
            check($sformatf("rnd.alu.op%0d", field(int'(e_cw), 7, 5)), 128'(alu_result_execute),
                  128'(ref_lane(field(int'(e_cw), 7, 5), int'(alu_src_A[7:0]), int'(alu_src_B[7:0]))));
            check($sformatf("rnd.valu.op%0d", field(int'(e_cw), 2, 5)), alu_vector_result_execute,
                  ref_vector(field(int'(e_cw), 2, 5), alu_src_vector_A, alu_src_vector_B));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
